// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array front end.
//   DATA_W          : width of one activation lane
//   lane_t          : one activation lane word
//   feeder_state_e  : input_feeder sequencer states (LOAD, STREAM, DRAIN)
// The lane-vector type needs the lane count N, which is a per-instance
// parameter, so vec_t is declared from lane_t inside input_feeder_if.
package tpu_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] lane_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/input_feeder_if.sv
// Bundle of the input_feeder upstream valid/ready port and the downstream
// stream toward the skew triangle.
//   in_valid/in_ready/in_data/in_last : tile load handshake
//   out_valid/out_data/out_first/out_last : replayed vectors (zeros when idle)
//   done     : one-cycle pulse at the end of the drain
//   tile_len : length of the tile being streamed
// Modports: master = upstream/observer side, slave = the feeder itself.
interface input_feeder_if #(
  parameter int N     = 256,
  parameter int DEPTH = 256
) ();
  import tpu_pkg::*;

  localparam int LEN_W = $clog2(DEPTH + 1);

  typedef lane_t vec_t [N];

  logic             in_valid;
  logic             in_ready;
  vec_t             in_data;
  logic             in_last;
  logic             out_valid;
  vec_t             out_data;
  logic             out_first;
  logic             out_last;
  logic             done;
  logic [LEN_W-1:0] tile_len;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, out_data, out_first, out_last, done, tile_len
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, out_data, out_first, out_last, done, tile_len
  );

endinterface

// File: rtl/feeder_buffer.sv
// Simple dual-port tile RAM: synchronous write, registered read, no reset so
// it maps onto block RAM (or can be swapped for a vendor macro).
//   clk             : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr   : read request, data appears on rd_data next cycle
//   rd_data         : registered read data (holds when rd_en is low)
module feeder_buffer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8192,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/input_feeder.sv
// Tile buffer and sequencer in front of the input skew triangle.  Loads up to
// DEPTH vectors, replays them one per cycle, then drives N-1 zero cycles so
// the triangle and array flush before the next tile is accepted.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : input_feeder_if.slave (load handshake, output stream, done,
//              tile_len)
module input_feeder
  import tpu_pkg::*;
#(
  parameter int N     = 256,
  parameter int DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst,
  input_feeder_if.slave  bus
);

  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (N > 2) ? $clog2(N - 1) : 1;
  localparam int VEC_W = N * DATA_W;

  localparam logic [1:0] S_LOAD   = LOAD;
  localparam logic [1:0] S_STREAM = STREAM;
  localparam logic [1:0] S_DRAIN  = DRAIN;

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DEPTH - 1);

  logic [1:0]       state_reg;
  logic [LEN_W-1:0] wr_ptr_reg;
  logic [LEN_W-1:0] rd_ptr_reg;
  logic [LEN_W-1:0] tile_len_reg;
  logic [CNT_W-1:0] drain_cnt_reg;
  logic             out_valid_reg;
  logic             out_first_reg;
  logic             out_last_reg;
  logic             done_reg;

  logic             handshake;
  logic             tile_end;
  logic             read_last;
  logic [VEC_W-1:0] wr_data;
  logic [VEC_W-1:0] rd_data;

  assign bus.in_ready = (state_reg == S_LOAD);
  assign handshake    = bus.in_valid && bus.in_ready;
  // The DEPTH-th vector closes the tile even without in_last.
  assign tile_end     = handshake && (bus.in_last || (wr_ptr_reg == LAST_IDX));
  assign read_last    = (rd_ptr_reg == (tile_len_reg - LEN_W'(1)));

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign wr_data[gi*DATA_W +: DATA_W] = bus.in_data[gi];
      // The RAM read register is the data half of the output register; it
      // is masked by out_valid so idle and reset cycles show zeros.
      assign bus.out_data[gi] = out_valid_reg ? rd_data[gi*DATA_W +: DATA_W]
                                              : '0;
    end
  endgenerate

  feeder_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (VEC_W),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (handshake),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (state_reg == S_STREAM),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_LOAD;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      tile_len_reg  <= '0;
      drain_cnt_reg <= '0;
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        S_LOAD: begin
          if (tile_end) begin
            tile_len_reg <= wr_ptr_reg + LEN_W'(1);
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            state_reg    <= S_STREAM;
          end else if (handshake) begin
            wr_ptr_reg <= wr_ptr_reg + LEN_W'(1);
          end
        end
        S_STREAM: begin
          out_valid_reg <= 1'b1;
          out_first_reg <= (rd_ptr_reg == '0);
          out_last_reg  <= read_last;
          rd_ptr_reg    <= rd_ptr_reg + LEN_W'(1);
          if (read_last) begin
            if (N == 1) begin
              // Nothing to flush: done coincides with the last vector.
              state_reg <= S_LOAD;
              done_reg  <= 1'b1;
            end else begin
              // N-1 drain cycles counted N-2 down to 0.
              state_reg     <= S_DRAIN;
              drain_cnt_reg <= CNT_W'(N - 2);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg <= S_LOAD;
            done_reg  <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= S_LOAD;
      endcase
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_first = out_first_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.done      = done_reg;
  assign bus.tile_len  = tile_len_reg;

endmodule

// File: tb/tb_input_feeder.sv
// Directed bench for input_feeder with N=4, DEPTH=8.  Vector k carries lane
// value 16*k + lane.  Inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.
module tb_input_feeder;

  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  input_feeder_if #(.N(N), .DEPTH(DEPTH)) bus ();

  input_feeder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] vec_pk(input int idx);
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < N; l++) r[l*32 +: 32] = 32'(16 * idx + l);
    return r;
  endfunction

  function automatic logic [127:0] out_pk();
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < N; l++) r[l*32 +: 32] = bus.out_data[l];
    return r;
  endfunction

  task automatic set_vec(input int idx);
    for (int l = 0; l < N; l++) bus.in_data[l] = 32'(16 * idx + l);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input bit v, input bit f, input bit l,
                             input logic [127:0] d, input bit dn, input bit r);
    chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(v));
    chk({tag, ".out_first"}, 128'(bus.out_first), 128'(f));
    chk({tag, ".out_last"},  128'(bus.out_last),  128'(l));
    chk({tag, ".out_data"},  out_pk(),             d);
    chk({tag, ".done"},      128'(bus.done),       128'(dn));
    chk({tag, ".in_ready"},  128'(bus.in_ready),   128'(r));
    $display("cycle %s: valid=%0b first=%0b last=%0b done=%0b ready=%0b data=%0h",
             tag, bus.out_valid, bus.out_first, bus.out_last, bus.done, bus.in_ready, out_pk());
  endtask

  // Offer one vector for a full cycle; in_ready must be high so it is taken.
  task automatic send(input string tag, input int idx, input bit last);
    step();
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    set_vec(idx);
    mid();
    chk({tag, ".hs_ready"}, 128'(bus.in_ready), 128'(1'b1));
    $display("load %s: vec=%0d last=%0b ready=%0b", tag, idx, last, bus.in_ready);
  endtask

  // Called right after the closing handshake cycle c; checks c+1 .. c+L+N
  // and returns mid-way through the done cycle.
  task automatic stream_tile(input string tag, input int base, input int len,
                             input bit preload, input int pre_idx);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    mid();
    check_cycle($sformatf("%s.c+1", tag), 0, 0, 0, '0, 0, 0);
    for (int k = 0; k < len; k++) begin
      step();
      mid();
      check_cycle($sformatf("%s.out%0d", tag, k), 1, k == 0, k == len - 1,
                  vec_pk(base + k), 0, 0);
      chk($sformatf("%s.tile_len%0d", tag, k), 128'(bus.tile_len), 128'(len));
    end
    for (int z = 0; z < N - 1; z++) begin
      step();
      if (z == N - 2 && preload) begin
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        set_vec(pre_idx);
      end
      mid();
      check_cycle($sformatf("%s.zero%0d", tag, z), 0, 0, 0, '0, z == N - 2, z == N - 2);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    set_vec(0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", 0, 0, 0, '0, 0, 1);
    chk("reset.tile_len", 128'(bus.tile_len), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // 3-vector tile: done at c+L+N = c+7
    send("t3.v0", 0, 0);
    send("t3.v1", 1, 0);
    send("t3.v2", 2, 1);
    stream_tile("t3", 0, 3, 0, 0);
    step();
    mid();
    chk("t3.done_drop", 128'(bus.done), 128'(0));

    // DEPTH overflow: 8 vectors without in_last, done at c+12
    for (int i = 0; i < DEPTH; i++) send($sformatf("ovf.v%0d", i), 20 + i, 0);
    stream_tile("ovf", 20, DEPTH, 0, 0);

    // 1-vector tile: first and last together, done at c+L+N = c+5
    send("t1.v0", 40, 1);
    stream_tile("t1", 40, 1, 0, 0);

    // Valid gaps: idle cycles carry junk data and in_last=1, never captured
    send("gap.v0", 50, 0);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;
    set_vec(99);
    mid();
    chk("gap.idle0_ready", 128'(bus.in_ready), 128'(1));
    send("gap.v1", 51, 0);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;
    set_vec(98);
    mid();
    chk("gap.idle1_ready", 128'(bus.in_ready), 128'(1));
    send("gap.v2", 52, 1);
    stream_tile("gap", 50, 3, 0, 0);

    // Reset in the second output cycle
    send("rs.v0", 60, 0);
    send("rs.v1", 61, 0);
    send("rs.v2", 62, 1);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    mid();
    step();
    mid();
    check_cycle("rs.out0", 1, 1, 0, vec_pk(60), 0, 0);
    step();
    check_cycle("rs.out1_pre", 1, 0, 0, vec_pk(61), 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_cycle("rs.async", 0, 0, 0, '0, 0, 1);
    chk("rs.async_tile_len", 128'(bus.tile_len), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    step();
    mid();
    check_cycle("rs.after", 0, 0, 0, '0, 0, 1);
    send("rs2.v0", 70, 0);
    send("rs2.v1", 71, 1);
    stream_tile("rs2", 70, 2, 0, 0);

    // Back-to-back: next tile offered from the done cycle
    send("bb.v0", 80, 0);
    send("bb.v1", 81, 1);
    stream_tile("bb", 80, 2, 1, 90);
    send("bb2.v1", 91, 1);
    stream_tile("bb2", 90, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
